// File: rtl/ip_misc_fifo_pkg.sv
// ip_misc_fifo_pkg
//   Shared helpers for the misc FIFO blocks: binary <-> Gray conversion of
//   pointers. Functions work on a fixed-width word; callers zero-extend their
//   pointer into ptr_word_t and truncate the result back to pointer width.
//   Zero-extension is safe for both directions because the extra MSBs are 0
//   in binary and in Gray.
package ip_misc_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ip_misc_sync_nff.sv
// ip_misc_sync_nff
//   N-flop synchroniser for a multi-bit bus whose value changes by at most one
//   bit per source clock (Gray-coded pointers).
// Ports:
//   clk  - destination clock
//   rstn - asynchronous active-low reset, clears the chain
//   d    - source-domain value
//   q    - value after STAGES destination flops
module ip_misc_sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // chain[0] is the metastability-capture flop, chain[STAGES-1] the output
    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ip_misc_fifo_async_gray.sv
// ip_misc_fifo_async_gray
//   Dual-clock FIFO with Gray-coded pointer crossing.
// Ports:
//   wr_clk, rd_clk   - independent write / read clocks
//   rstn             - asynchronous active-low reset for both domains
//   wr_en, wr_data   - write request and word
//   wr_full          - no space; writes ignored
//   wr_almost_full   - wr_level >= AF_LEVEL
//   wr_level         - occupancy as seen from the write side
//   wr_overflow      - one-cycle pulse on write while full
//   rd_en            - read request
//   rd_data, rd_valid- registered read word and its one-cycle valid
//   rd_empty         - no data; reads ignored
//   rd_almost_empty  - rd_level <= AE_LEVEL
//   rd_level         - occupancy as seen from the read side
//   rd_underflow     - one-cycle pulse on read while empty
module ip_misc_fifo_async_gray
    import ip_misc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_underflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    // Storage is deliberately not reset; pointers define what is valid.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wptr, wptr_gray, wptr_next, wgray_next;
    logic [PW-1:0] rgray_sync, rptr_sync_bin;
    logic          wr_accept, full_next;

    assign wr_accept     = wr_en & ~wr_full;
    assign wptr_next     = wptr + PW'(wr_accept);
    assign wgray_next    = PW'(bin2gray(ptr_word_t'(wptr_next)));
    assign rptr_sync_bin = PW'(gray2bin(ptr_word_t'(rgray_sync)));

    // Full: writer is exactly one lap ahead, i.e. Gray pointers differ only
    // in the two MSBs.
    assign full_next = (wgray_next == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            wptr        <= '0;
            wptr_gray   <= '0;
            wr_full     <= 1'b0;
            wr_level    <= '0;
            wr_overflow <= 1'b0;
        end else begin
            wptr        <= wptr_next;
            wptr_gray   <= wgray_next;
            wr_full     <= full_next;
            wr_level    <= wptr_next - rptr_sync_bin;
            wr_overflow <= wr_en & wr_full;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    assign wr_almost_full = (wr_level >= AF_THR);

    // ---------------- read domain ----------------
    logic [PW-1:0] rptr, rptr_gray, rptr_next, rgray_next;
    logic [PW-1:0] wgray_sync, wptr_sync_bin;
    logic          rd_accept, empty_next;

    assign rd_accept     = rd_en & ~rd_empty;
    assign rptr_next     = rptr + PW'(rd_accept);
    assign rgray_next    = PW'(bin2gray(ptr_word_t'(rptr_next)));
    assign wptr_sync_bin = PW'(gray2bin(ptr_word_t'(wgray_sync)));
    assign empty_next    = (rgray_next == wgray_sync);

    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            rptr         <= '0;
            rptr_gray    <= '0;
            rd_empty     <= 1'b1;
            rd_level     <= '0;
            rd_underflow <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            rptr         <= rptr_next;
            rptr_gray    <= rgray_next;
            rd_empty     <= empty_next;
            rd_level     <= wptr_sync_bin - rptr_next;
            rd_underflow <= rd_en & rd_empty;
            rd_valid     <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rd_almost_empty = (rd_level <= AE_THR);

    // ---------------- pointer crossings ----------------
    ip_misc_sync_nff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk  (rd_clk),
        .rstn (rstn),
        .d    (wptr_gray),
        .q    (wgray_sync)
    );

    ip_misc_sync_nff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk  (wr_clk),
        .rstn (rstn),
        .d    (rptr_gray),
        .q    (rgray_sync)
    );

endmodule

// File: tb/tb_ip_misc_fifo_async_gray.sv
// tb_ip_misc_fifo_async_gray
//   Directed bench for the Gray-pointer async FIFO. Time unit is treated as
//   0.1 ns: wr half-period 50 -> 100 MHz, rd half-period 135 -> ~37 MHz.
//   Inputs are driven and outputs sampled on falling edges.
module tb_ip_misc_fifo_async_gray;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          rstn   = 1'b0;
    logic          wr_en  = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en  = 1'b0;
    logic          wr_full, wr_almost_full, wr_overflow;
    logic [AW:0]   wr_level, rd_level;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_empty, rd_almost_empty, rd_underflow;

    int checks = 0;
    int errors = 0;
    int wr_half = 50;
    int rd_half = 135;

    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    ip_misc_fifo_async_gray #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(2),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .wr_clk         (wr_clk),
        .rd_clk         (rd_clk),
        .rstn           (rstn),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .wr_level       (wr_level),
        .wr_overflow    (wr_overflow),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_empty       (rd_empty),
        .rd_almost_empty(rd_almost_empty),
        .rd_level       (rd_level),
        .rd_underflow   (rd_underflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Random traffic with enables gated by the flags, scoreboarded in order.
    task automatic run_random(input int n);
        int sent = 0;
        int got  = 0;
        int ovf  = 0;
        int unf  = 0;
        logic [DW-1:0] sb[$];
        fork
            begin
                for (int c = 0; c < 8000 && sent < n; c++) begin
                    @(negedge wr_clk);
                    if (wr_overflow) ovf++;
                    if (!wr_full && ($urandom_range(0, 1) == 1)) begin
                        wr_en   = 1'b1;
                        wr_data = $urandom;
                        sb.push_back(wr_data);
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 8000 && got < n; c++) begin
                    @(negedge rd_clk);
                    if (rd_underflow) unf++;
                    if (rd_valid) begin
                        check("rand_sb_has_entry", (sb.size() > 0), 1);
                        if (sb.size() > 0) check("rand_data", rd_data, sb.pop_front());
                        got++;
                    end
                    rd_en = (got < n) && !rd_empty && ($urandom_range(0, 3) != 0);
                end
                rd_en = 1'b0;
            end
        join
        check("rand_sent", sent, n);
        check("rand_got", got, n);
        check("rand_no_overflow", ovf, 0);
        check("rand_no_underflow", unf, 0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, fulls, empties;
        bit started;

        // ---- reset state ----
        repeat (3) @(negedge wr_clk);
        check("rst_wr_full", wr_full, 0);
        check("rst_wr_almost_full", wr_almost_full, 0);
        check("rst_wr_level", wr_level, 0);
        check("rst_wr_overflow", wr_overflow, 0);
        check("rst_rd_empty", rd_empty, 1);
        check("rst_rd_almost_empty", rd_almost_empty, 1);
        check("rst_rd_level", rd_level, 0);
        check("rst_rd_underflow", rd_underflow, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        rstn = 1'b1;
        repeat (2) @(negedge rd_clk);

        // ---- fill 0..15, almost-full at 14, full at 16, overflow on 17th ----
        for (int i = 0; i < 16; i++) begin
            @(negedge wr_clk);
            if (i == 13) check("af_at_13", wr_almost_full, 0);
            if (i == 14) begin
                check("af_at_14", wr_almost_full, 1);
                check("wr_level_14", wr_level, 14);
            end
            wr_en   = 1'b1;
            wr_data = i;
        end
        @(negedge wr_clk);
        check("full_after_16", wr_full, 1);
        check("wr_level_16", wr_level, 16);
        check("no_ovf_yet", wr_overflow, 0);
        wr_data = 32'h99;
        @(negedge wr_clk);
        check("ovf_pulse", wr_overflow, 1);
        check("still_full", wr_full, 1);
        wr_en = 1'b0;
        @(negedge wr_clk);
        check("ovf_one_cycle", wr_overflow, 0);

        // ---- drain 0..15 in order, almost-empty at level 2 ----
        repeat (4) @(negedge rd_clk);
        check("rd_not_empty", rd_empty, 0);
        check("rd_level_16", rd_level, 16);
        check("ae_at_16", rd_almost_empty, 0);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge rd_clk);
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, i);
            if (i == 12) check("ae_at_level3", rd_almost_empty, 0);
            if (i == 13) check("ae_at_level2", rd_almost_empty, 1);
            if (i == 15) rd_en = 1'b0;
        end
        @(negedge rd_clk);
        check("drain_valid_off", rd_valid, 0);
        check("drain_empty", rd_empty, 1);
        check("drain_level0", rd_level, 0);

        // ---- underflow on empty ----
        rd_en = 1'b1;
        @(negedge rd_clk);
        check("unf_pulse", rd_underflow, 1);
        check("unf_no_valid", rd_valid, 0);
        check("unf_data_held", rd_data, 15);
        rd_en = 1'b0;
        @(negedge rd_clk);
        check("unf_one_cycle", rd_underflow, 0);
        repeat (6) @(negedge wr_clk);
        check("wr_full_cleared", wr_full, 0);
        check("wr_level_0", wr_level, 0);

        // ---- reset with 8 words held ----
        for (int i = 0; i < 8; i++) begin
            @(negedge wr_clk);
            wr_en   = 1'b1;
            wr_data = 32'h10 + i;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
        repeat (8) @(negedge wr_clk);
        check("held_wr_level_8", wr_level, 8);
        rstn = 1'b0;
        #1;
        check("mid_rst_rd_empty", rd_empty, 1);
        check("mid_rst_wr_level", wr_level, 0);
        check("mid_rst_rd_level", rd_level, 0);
        repeat (2) @(negedge wr_clk);
        rstn = 1'b1;
        @(negedge wr_clk);
        wr_en   = 1'b1;
        wr_data = 32'hA5;
        @(negedge wr_clk);
        wr_en = 1'b0;
        @(negedge rd_clk);
        for (int k = 0; k < 10 && rd_empty; k++) @(negedge rd_clk);
        check("a5_visible", rd_empty, 0);
        rd_en = 1'b1;
        @(negedge rd_clk);
        rd_en = 1'b0;
        check("a5_valid", rd_valid, 1);
        check("a5_data", rd_data, 32'hA5);
        repeat (2) @(negedge rd_clk);

        // ---- random traffic, both clock ratios ----
        run_random(500);
        wr_half = 135;
        rd_half = 50;
        repeat (4) @(negedge wr_clk);
        run_random(500);

        // ---- rate-matched streaming, 3 laps of the pointer space ----
        wr_half = 50;
        rd_half = 50;
        repeat (6) @(negedge rd_clk);
        sent = 0; got = 0; fulls = 0; empties = 0; started = 1'b0;
        fork
            begin
                for (int c = 0; c < 2000 && sent < 48; c++) begin
                    @(negedge wr_clk);
                    if (wr_full) fulls++;
                    if (!wr_full) begin
                        wr_en   = 1'b1;
                        wr_data = 32'h1000 + sent;
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                for (int c = 0; c < 2000 && got < 48; c++) begin
                    @(negedge rd_clk);
                    if (rd_valid) begin
                        check("stream_data", rd_data, 32'h1000 + got);
                        got++;
                    end
                    if (!started && rd_level >= 4) started = 1'b1;
                    if (started && rd_empty && got < 48) empties++;
                    rd_en = started && !rd_empty && (got < 48);
                end
                rd_en = 1'b0;
            end
        join
        check("stream_sent", sent, 48);
        check("stream_got", got, 48);
        check("stream_no_full", fulls, 0);
        check("stream_no_empty", empties, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
